// File: rtl/serial_rx_deserializer.sv
// Serial receiver: rebuilds four WIDTH-bit words (A-D) from an LSB-first bit
// stream framed by a one-cycle rx_start strobe; pulses received_n when done.
module serial_rx_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       rx_start,
    input  logic                       data,
    output logic [WIDTH-1:0]           outA,
    output logic [WIDTH-1:0]           outB,
    output logic [WIDTH-1:0]           outC,
    output logic [WIDTH-1:0]           outD,
    output logic [$clog2(WIDTH)-1:0]   QbitRX,
    output logic [1:0]                 QwrdRX,
    output logic                       received_n,
    output logic                       busy,
    output logic                       err
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BW-1:0]      qbit_q, qbit_d;
    logic [1:0]         qwrd_q, qwrd_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   out_q [4];
    logic [WIDTH-1:0]   out_d [4];
    logic [WIDTH-1:0]   word_w;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            qbit_q  <= '0;
            qwrd_q  <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            qbit_q  <= qbit_d;
            qwrd_q  <= qwrd_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rx_start) state_d = RECV;
            RECV: if (!rx_start && qbit_q == LAST_BIT && qwrd_q == 2'd3) state_d = DONE;
            DONE: state_d = rx_start ? RECV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rx_start wins over a word completion on the same edge: an aborted frame never writes.
    always_comb begin
        shift_d = shift_q;
        qbit_d  = qbit_q;
        qwrd_d  = qwrd_q;
        err_d   = 1'b0;
        out_d   = out_q;
        word_w  = shift_q;
        word_w[qbit_q] = data;
        if (rx_start) begin
            shift_d    = '0;
            shift_d[0] = data;
            qbit_d     = BW'(1);
            qwrd_d     = 2'd0;
            err_d      = (state_q == RECV);
        end else if (state_q == RECV) begin
            shift_d = word_w;
            if (qbit_q == LAST_BIT) begin
                out_d[qwrd_q] = word_w;
                qbit_d        = '0;
                qwrd_d        = qwrd_q + 2'd1;
            end else begin
                qbit_d = qbit_q + BW'(1);
            end
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        received_n = (state_q != DONE);
        err        = err_q;
        QbitRX     = qbit_q;
        QwrdRX     = qwrd_q;
        outA       = out_q[0];
        outB       = out_q[1];
        outC       = out_q[2];
        outD       = out_q[3];
    end

endmodule

// File: tb/tb_serial_rx_deserializer.sv
// Self-checking bench: a frame-position model predicts every output each cycle,
// with literal checks on frame timing, captured words, abort and reset behaviour.
module tb_serial_rx_deserializer;

    localparam int W  = 4;
    localparam int FB = 4 * W;
    localparam logic [FB-1:0] F1 = 16'hF0C5;
    localparam logic [FB-1:0] F2 = 16'h3A0F;
    localparam logic [FB-1:0] FA = 16'h5C96;
    localparam logic [FB-1:0] F3 = 16'h8E53;
    localparam logic [FB-1:0] F4 = 16'h1234;

    logic clk = 1'b0;
    logic clr_n, rx_start, data;
    logic [W-1:0] outA, outB, outC, outD;
    logic [$clog2(W)-1:0] QbitRX;
    logic [1:0] QwrdRX;
    logic received_n, busy, err;

    serial_rx_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .clr_n(clr_n), .rx_start(rx_start), .data(data),
        .outA(outA), .outB(outB), .outC(outC), .outD(outD),
        .QbitRX(QbitRX), .QwrdRX(QwrdRX),
        .received_n(received_n), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Model: pos = index of next bit in the frame (0 when no frame), done = pulse cycle.
    int        pos = 0;
    bit        done = 1'b0;
    bit        err_m = 1'b0;
    bit        fbits [FB];
    logic [W-1:0] m_out [4] = '{default: '0};

    function automatic logic [W-1:0] model_word(input int w);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = fbits[w*W + i];
        return v;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pos = 0; done = 1'b0; err_m = 1'b0;
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else begin
            err_m = 1'b0;
            if (rx_start) begin
                err_m = (pos > 0);
                fbits[0] = data;
                pos = 1;
                done = 1'b0;
            end else if (pos > 0) begin
                fbits[pos] = data;
                if (pos % W == W - 1) m_out[pos / W] = model_word(pos / W);
                pos++;
                if (pos == FB) begin
                    pos = 0;
                    done = 1'b1;
                end
            end else begin
                done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (clr_n === 1'b1) begin
            chk("outA", 32'(outA), 32'(m_out[0]));
            chk("outB", 32'(outB), 32'(m_out[1]));
            chk("outC", 32'(outC), 32'(m_out[2]));
            chk("outD", 32'(outD), 32'(m_out[3]));
            chk("QbitRX", 32'(QbitRX), 32'(pos % W));
            chk("QwrdRX", 32'(QwrdRX), 32'(pos / W));
            chk("busy", 32'(busy), 32'((pos > 0) || done));
            chk("received_n", 32'(received_n), 32'(!done));
            chk("err", 32'(err), 32'(err_m));
        end
    end

    int pulse_q [$];
    logic [FB-1:0] cap_q [$];
    int err_cnt = 0;
    int idle_cnt = 0;
    logic [W-1:0] err_outA, err_outB;

    always @(negedge clk) begin
        if (clr_n === 1'b1) begin
            if (received_n === 1'b0) begin
                pulse_q.push_back(cyc);
                cap_q.push_back({outD, outC, outB, outA});
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_outA = outA;
                err_outB = outB;
            end
            if (busy === 1'b0) idle_cnt++;
        end
    end

    int start_cyc;

    task automatic send_frame(input logic [FB-1:0] f, input int nbits, input bit ctr_chk);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            if (ctr_chk && (k == 3 || k == 5 || k == 12)) begin
                chk("QbitRX_lit", 32'(QbitRX), 32'(k % W));
                chk("QwrdRX_lit", 32'(QwrdRX), 32'(k / W));
            end
            rx_start = (k == 0);
            data = f[k];
            if (k == 0) start_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_start = 1'b0;
            data = 1'($urandom);
        end
    endtask

    initial begin
        int start1, start3, idle_snap;
        logic [63:0] r;
        logic [FB-1:0] f;
        int n;

        clr_n = 1'b0; rx_start = 1'b0; data = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", 32'({outD, outC, outB, outA}), 32'h0);
        chk("rst_received_n", 32'(received_n), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_ctrs", 32'({QwrdRX, QbitRX}), 32'h0);
        clr_n = 1'b1;
        idle(3);

        send_frame(F1, 16, 1'b1);
        start1 = start_cyc;
        idle_snap = idle_cnt;
        send_frame(F2, 16, 1'b0);
        chk("busy_b2b", 32'(idle_cnt), 32'(idle_snap));
        idle(2);
        chk("pulses_2", 32'(pulse_q.size()), 32'd2);
        if (pulse_q.size() >= 2) begin
            chk("pulse1_delay", 32'(pulse_q[0] - start1), 32'd16);
            chk("pulse_spacing", 32'(pulse_q[1] - pulse_q[0]), 32'd16);
            chk("frame1_words", 32'(cap_q[0]), 32'h0000F0C5);
            chk("frame2_words", 32'(cap_q[1]), 32'h00003A0F);
        end

        send_frame(FA, 6, 1'b0);
        send_frame(F3, 16, 1'b0);
        start3 = start_cyc;
        idle(3);
        chk("err_count", 32'(err_cnt), 32'd1);
        chk("err_outB_held", 32'(err_outB), 32'h0);
        chk("err_outA_kept", 32'(err_outA), 32'h6);
        chk("pulses_3", 32'(pulse_q.size()), 32'd3);
        if (pulse_q.size() >= 3) begin
            chk("pulse3_delay", 32'(pulse_q[2] - start3), 32'd16);
            chk("frame3_words", 32'(cap_q[2]), 32'h00008E53);
        end

        send_frame(F4, 10, 1'b0);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_outs", 32'({outD, outC, outB, outA}), 32'h0);
        chk("arst_received_n", 32'(received_n), 32'h1);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ctrs", 32'({QwrdRX, QbitRX}), 32'h0);
        rx_start = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            data = ~data;
        end
        idle(1);
        chk("post_rst_outs", 32'({outD, outC, outB, outA}), 32'h0);
        chk("post_rst_pulses", 32'(pulse_q.size()), 32'd3);

        repeat (30) begin
            r = {$urandom(), $urandom()};
            f = r[FB-1:0];
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FB - 1)) : FB;
            send_frame(f, n, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_rx_deserializer.md
# serial_rx_deserializer

Receiving end of the four-word parallel-to-serial link: captures the 1-bit `data` stream, marked by a one-cycle `rx_start` strobe, and rebuilds the four parallel words A-D. The block shifts each word in LSB first, publishes each completed word to its output register, and pulses active-low `received_n` when the frame is complete. It sits at the far end of the serial line, on the same clock as the transmitter, and exposes its bit and word counters for debug and for cross-checking against the transmitter.

## Interface
- `WIDTH`, default 4: bits per word. The frame is always 4 words, so a frame is 4*WIDTH bits.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `clr_n`  input  1  asynchronous active-low reset.
- `rx_start`  input  1  frame strobe, high for the one cycle that carries bit 0 of word A.
- `data`  input  1  serial data, sampled on every rising edge while a frame is active.
- `outA`, `outB`, `outC`, `outD`  output  WIDTH each  received words, registered and held until overwritten.
- `QbitRX`  output  clog2(WIDTH)  index of the next bit to be sampled within the current word.
- `QwrdRX`  output  2  index of the word currently being received (0=A … 3=D).
- `received_n`  output  1  active-low, low for exactly one cycle after the last bit of word D.
- `busy`  output  1  high while a frame is in progress.
- `err`  output  1  one-cycle high pulse when `rx_start` arrives mid-frame.

## Operation
- The FSM has three states: IDLE, RECV and DONE.
- **IDLE**
  - `busy`=0; both counters are held at 0.
  - If `rx_start`=1, the block samples `data` as bit 0 of word A, sets `QbitRX`=1 and moves to RECV.
  - `data` is ignored without `rx_start`.
- **RECV**
  - Every cycle, `data` is shifted into the shift register at position `QbitRX`, so the word is assembled LSB first.
  - When `QbitRX`=WIDTH-1, the completed word is written to `out[QwrdRX]`, `QbitRX` wraps to 0 and `QwrdRX` increments.
  - When the completed word is word D (`QwrdRX`=3), the FSM goes to DONE instead, and `QwrdRX` wraps to 0.
- **DONE**
  - `received_n`=0 for one cycle, then the FSM returns to IDLE.
  - `rx_start`=1 while in DONE is legal. It is treated exactly as `rx_start` in IDLE (bit 0 of a new frame is sampled and the FSM enters RECV), so frames can be sent back to back with no gap. `received_n` still pulses that cycle.
- **`rx_start` in RECV**
  - The current frame is aborted; partial words are never written.
  - `err` pulses for one cycle.
  - The new frame restarts with `data` as bit 0 of word A: `QbitRX`=1, `QwrdRX`=0.
  - Output registers already written by the aborted frame keep their values.
- Output registers change only on word completion. A word register is never partially updated.
- **Reset** (`clr_n`=0, at any time, including mid-frame):
  - State becomes IDLE.
  - `outA`-`outD` = 0, `QbitRX` = 0, `QwrdRX` = 0, `busy` = 0, `err` = 0, `received_n` = 1, shift register = 0.
  - The interrupted frame is discarded. Capture does not resume until the next `rx_start` after release.

## Timing
- Bit k of a frame (k=0…4*WIDTH-1) is sampled on rising edge E0+k, where E0 is the edge on which `rx_start`=1 is sampled.
- `outA` updates on edge E0+WIDTH-1 and is visible after that edge. In general, word w updates on edge E0+(w+1)*WIDTH-1.
- `received_n` is low in the cycle following edge E0+4*WIDTH-1, i.e. the same cycle in which `outD` first shows the new value.
- `busy` rises after E0 and falls after the DONE cycle. It stays high across back-to-back frames.
- All outputs are registered; there is no combinational path from input to output.
- Minimum frame spacing: `rx_start` period 4*WIDTH+1 cycles, or 4*WIDTH cycles when the next `rx_start` coincides with DONE.

## Test plan
- **Single frame:** hold `clr_n`=0 for 2 cycles, then send one frame (WIDTH=4) with words A=0101, B=1100, C=0000, D=1111, LSB-first stream 1010 0011 0000 1111.
  - Each register is written on its word's completion edge, ending with `outA`=0101, `outB`=1100, `outC`=0000, `outD`=1111.
  - `received_n`=0 for exactly one cycle, 16 cycles after `rx_start`.
- **Counters:** during the frame above, `QbitRX` cycles 1,2,3,0 and `QwrdRX` steps 0→1→2→3 on word boundaries. Both read 0 in IDLE.
- **Back-to-back frames:** after the first frame, assert `rx_start` during the DONE cycle with A=1111, B=0000, C=1010, D=0011.
  - Second `received_n` pulse occurs 16 cycles after the first.
  - Outputs update to the new words.
  - `busy` never drops.
- **Mid-frame restart:** assert `rx_start` at bit 2 of word B.
  - `err`=1 for one cycle; `outB` is unchanged.
  - A full frame follows and completes correctly; `received_n` pulses 16 cycles after the second `rx_start`.
- **Reset mid-frame:** drop `clr_n` during word C.
  - Outputs go to 0 and `received_n` goes to 1 immediately (asynchronous).
  - No `received_n` pulse occurs.
  - After release, `data` toggling without `rx_start` leaves all outputs at 0.
